// File: rtl/serial_addsub_pkg.sv
// Shared types and defaults for the bit-serial add/subtract unit.
package serial_addsub_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Carry-in seen by the adder for a given operation.
   function automatic logic initial_carry(input logic sub, input logic cin);
      return sub ? 1'b1 : cin;
   endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// overflow exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
   parameter int WIDTH = serial_addsub_pkg::WIDTH_DEFAULT
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             overflow;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout, overflow
   );
`else
   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout
   );
`endif
endinterface

// File: rtl/serial_addsub_fa_bit.sv
// Combinational 1-bit full adder cell reused for every bit position.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract engine: one full adder plus carry FF, LSB first.
// Define SERIAL_ADDSUB_OVF_EN to register signed overflow alongside sum.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input logic          clk,
   input logic          rst,
   serial_addsub_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_RUN  = 2'(RUN);
   localparam logic [1:0] ST_DONE = 2'(DONE);

   logic [1:0]       state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] sh_res;
   logic             carry;
   logic [CNT_W-1:0] count;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             fa_s;
   logic             fa_co;
   logic             load;
   logic             last_bit;

   fa_bit u_fa (
      .a  (sh_a[0]),
      .b  (sh_b[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      load     = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
      last_bit = (state == ST_RUN) && (count == CNT_W'(WIDTH - 1));
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_q;

   // Carry into the MSB is the carry FF on the final bit; carry out is fa_co.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (last_bit) begin
         ovf_q <= carry ^ fa_co;
      end
   end

   assign bus.overflow = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         sh_a   <= '0;
         sh_b   <= '0;
         sh_res <= '0;
         carry  <= 1'b0;
         count  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (load) begin
                  sh_a   <= bus.a;
                  sh_b   <= bus.sub ? ~bus.b : bus.b;
                  carry  <= initial_carry(bus.sub, bus.cin);
                  count  <= '0;
                  busy_q <= 1'b1;
                  state  <= ST_RUN;
               end else begin
                  state  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sh_res <= {fa_s, sh_res[WIDTH-1:1]};
               sh_a   <= sh_a >> 1;
               sh_b   <= sh_b >> 1;
               carry  <= fa_co;
               count  <= count + 1'b1;
               if (last_bit) begin
                  // sh_res is not yet updated here, so splice the final bit in directly.
                  sum_q  <= {fa_s, sh_res[WIDTH-1:1]};
                  cout_q <= fa_co;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vectors, random ops vs arithmetic model.
module tb_serial_addsub;
   import serial_addsub_pkg::*;

   localparam int W       = 8;
   localparam int TIMEOUT = 100;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   serial_addsub_if #(.WIDTH(W)) bus ();

   serial_addsub #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         sub;
      logic         cin;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   // Plain-integer reference: result mod 2^W, unsigned carry / no-borrow, signed range check.
   function automatic void model(input logic s, input logic c, input logic [W-1:0] x,
                                 input logic [W-1:0] y, output logic [W-1:0] r,
                                 output logic co, output logic ov);
      longint unsigned ux, uy, full;
      longint sx, sy, sres, smax, smin;
      ux   = longint'(x);
      uy   = longint'(y);
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      if (!s) begin
         full = ux + uy + longint'(c);
         co   = (full >= (64'd1 << W));
         sres = sx + sy + longint'(c);
      end else begin
         full = ux - uy;
         co   = (ux >= uy);
         sres = sx - sy;
      end
      r  = W'(full);
      ov = (sres > smax) || (sres < smin);
   endfunction

   task automatic run_op(input logic s, input logic c, input logic [W-1:0] x,
                         input logic [W-1:0] y, output int lat);
      bus.sub   = s;
      bus.cin   = c;
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.sub   = 1'($urandom);
      bus.cin   = 1'($urandom);
      lat = 0;
      while (bus.done !== 1'b1 && lat < TIMEOUT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.sum !== '0) begin
         failures++;
         $display("FAIL reset busy/done/cout=%b%b%b sum=%h expected 000 sum=00",
                  bus.busy, bus.done, bus.cout, bus.sum);
      end
`ifdef SERIAL_ADDSUB_OVF_EN
      checks++;
      if (bus.overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_ovf got=%b expected=0", bus.overflow);
      end
`endif
   endtask

   task automatic test_directed();
      vec_t vecs[5];
      int   lat;
      vecs[0] = '{1'b0, 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      foreach (vecs[i]) begin
         run_op(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, lat);
         checks++;
         if (lat !== W) begin
            failures++;
            $display("FAIL directed_latency[%0d] got=%0d expected=%0d", i, lat, W);
         end
         checks++;
         if (bus.sum !== vecs[i].sum || bus.cout !== vecs[i].cout) begin
            failures++;
            $display("FAIL directed_result[%0d] sum=%h cout=%b expected sum=%h cout=%b",
                     i, bus.sum, bus.cout, vecs[i].sum, vecs[i].cout);
         end
`ifdef SERIAL_ADDSUB_OVF_EN
         checks++;
         if (bus.overflow !== vecs[i].ovf) begin
            failures++;
            $display("FAIL directed_ovf[%0d] got=%b expected=%b", i, bus.overflow, vecs[i].ovf);
         end
`endif
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL directed_done_pulse[%0d] got=%b expected=0", i, bus.done);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, r;
      logic         s, c, co, ov;
      int           lat;
      for (int n = 0; n < 40; n++) begin
         x = W'($urandom);
         y = W'($urandom);
         s = 1'($urandom);
         c = 1'($urandom);
         model(s, c, x, y, r, co, ov);
         run_op(s, c, x, y, lat);
         checks++;
         if (lat !== W || bus.sum !== r || bus.cout !== co) begin
            failures++;
            $display("FAIL random[%0d] sub=%b cin=%b a=%h b=%h lat=%0d sum=%h cout=%b expected lat=%0d sum=%h cout=%b",
                     n, s, c, x, y, lat, bus.sum, bus.cout, W, r, co);
         end
`ifdef SERIAL_ADDSUB_OVF_EN
         checks++;
         if (bus.overflow !== ov) begin
            failures++;
            $display("FAIL random_ovf[%0d] got=%b expected=%b", n, bus.overflow, ov);
         end
`endif
         if (n % 3 == 0) @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] prev;
      int           lat;
      prev      = bus.sum;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = 8'h01;
      bus.b     = 8'h01;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'hAA;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 8'h55;
      bus.sub   = 1'b1;
      checks++;
      if (bus.busy !== 1'b1 || bus.sum !== prev) begin
         failures++;
         $display("FAIL ignore_midrun busy=%b sum=%h expected busy=1 sum=%h", bus.busy, bus.sum, prev);
      end
      lat = 3;
      while (bus.done !== 1'b1 && lat < TIMEOUT) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== W || bus.sum !== 8'h02 || bus.cout !== 1'b0) begin
         failures++;
         $display("FAIL ignore_start lat=%0d sum=%h cout=%b expected lat=%0d sum=02 cout=0",
                  lat, bus.sum, bus.cout, W);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] r;
      logic         co, ov;
      int           lat;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = 8'h21;
      bus.b     = 8'h43;
      bus.start = 1'b1;
      @(negedge clk);
      lat = 0;
      while (bus.done !== 1'b1 && lat < TIMEOUT) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== W || bus.sum !== 8'h64) begin
         failures++;
         $display("FAIL b2b_first lat=%0d sum=%h expected lat=%0d sum=64", lat, bus.sum, W);
      end
      bus.sub = 1'b1;
      bus.a   = 8'h30;
      bus.b   = 8'h45;
      model(1'b1, 1'b0, 8'h30, 8'h45, r, co, ov);
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_restart done=%b busy=%b expected done=0 busy=1", bus.done, bus.busy);
      end
      lat = 0;
      while (bus.done !== 1'b1 && lat < TIMEOUT) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== W || bus.sum !== r || bus.cout !== co) begin
         failures++;
         $display("FAIL b2b_second lat=%0d sum=%h cout=%b expected lat=%0d sum=%h cout=%b",
                  lat, bus.sum, bus.cout, W, r, co);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      logic seen_done;
      int   lat;
      run_op(1'b0, 1'b0, 8'h12, 8'h34, lat);
      checks++;
      if (bus.sum !== 8'h46) begin
         failures++;
         $display("FAIL midrun_setup sum=%h expected=46", bus.sum);
      end
      @(negedge clk);
      bus.a     = 8'h77;
      bus.b     = 8'h11;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0) begin
         failures++;
         $display("FAIL midrun_reset busy=%b done=%b sum=%h expected busy=0 done=0 sum=00",
                  bus.busy, bus.done, bus.sum);
      end
      seen_done = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin
         failures++;
         $display("FAIL midrun_no_done got=%b expected=0", seen_done);
      end
      run_op(1'b0, 1'b1, 8'h0F, 8'h0F, lat);
      checks++;
      if (lat !== W || bus.sum !== 8'h1F || bus.cout !== 1'b0) begin
         failures++;
         $display("FAIL midrun_fresh lat=%0d sum=%h cout=%b expected lat=%0d sum=1F cout=0",
                  lat, bus.sum, bus.cout, W);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
